dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_controller.sv | 139 +++++++++++++
 tb/tb_dcache_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through / write-allocate data-cache controller.
// Tags and valid bits are held here; data words live in an external array.
module dcache_controller #(
    parameter int unsigned INDEX_WIDTH = 3,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cpu_req_i,
    input  logic                   cpu_we_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic [31:0]            cpu_wdata_i,
    output logic [31:0]            cpu_rdata_o,
    output logic                   cpu_ready_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i,
    input  logic                   mem_ack_i,
    output logic [INDEX_WIDTH-1:0] arr_idx_o,
    output logic                   arr_we_o,
    output logic [31:0]            arr_wdata_o,
    input  logic [31:0]            arr_rdata_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic [CNT_WIDTH-1:0]   hit_cnt_o,
    output logic [CNT_WIDTH-1:0]   miss_cnt_o
);
    localparam int unsigned LINES     = 1 << INDEX_WIDTH;
    localparam int unsigned TAG_WIDTH = 30 - INDEX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                 state;
    logic [TAG_WIDTH-1:0]   tags [LINES];
    logic [LINES-1:0]       valid;
    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   hit;
    logic                   line_update;
    logic                   unused_addr;

    assign idx         = cpu_addr_i[INDEX_WIDTH+1:2];
    assign tag         = cpu_addr_i[31:INDEX_WIDTH+2];
    assign hit         = valid[idx] && (tags[idx] == tag);
    assign line_update = (state != IDLE) && mem_ack_i;
    assign unused_addr = ^cpu_addr_i[1:0];

    assign mem_addr_o  = {cpu_addr_i[31:2], 2'b00};
    assign mem_wdata_o = cpu_wdata_i;
    assign arr_idx_o   = idx;
    assign busy_o      = (state != IDLE);

    // Tag storage has no reset; a line only becomes usable through its valid bit.
    always_ff @(posedge clk_i) begin
        if (line_update) begin
            tags[idx] <= tag;
        end
    end

    // FSM, valid bits and saturating counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            valid      <= '0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        valid <= '0;
                    end else if (cpu_req_i) begin
                        if (cpu_we_i) begin
                            state <= WRITE;
                        end else if (hit) begin
                            if (hit_cnt_o != CNT_MAX) hit_cnt_o <= hit_cnt_o + CNT_WIDTH'(1);
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack_i) begin
                        valid[idx] <= 1'b1;
                        if (miss_cnt_o != CNT_MAX) miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        valid[idx] <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and array-write decode; the hit path completes in the request cycle.
    always_comb begin
        cpu_ready_o = 1'b0;
        cpu_rdata_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        arr_we_o    = 1'b0;
        arr_wdata_o = '0;
        case (state)
            IDLE: begin
                if (!flush_i && cpu_req_i && !cpu_we_i && hit) begin
                    cpu_ready_o = 1'b1;
                    cpu_rdata_o = arr_rdata_i;
                end
            end
            FILL: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    cpu_ready_o = 1'b1;
                    cpu_rdata_o = mem_rdata_i;
                    arr_we_o    = 1'b1;
                    arr_wdata_o = mem_rdata_i;
                end
            end
            WRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                if (mem_ack_i) begin
                    cpu_ready_o = 1'b1;
                    arr_we_o    = 1'b1;
                    arr_wdata_o = cpu_wdata_i;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus random
// accesses scored against a line-level cache model and a word-addressed memory.
module tb_dcache_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  arr_idx;
    logic        arr_we;
    logic [31:0] arr_wdata, arr_rdata;
    logic        flush, busy;
    logic [15:0] hit_cnt, miss_cnt;

    int checks   = 0;
    int failures = 0;

    // External data array seen by the controller.
    logic [31:0] arr [8];
    assign arr_rdata = arr[arr_idx];
    always @(posedge clk) if (arr_we) arr[arr_idx] <= arr_wdata;

    // Reference model: backing memory plus per-line valid/tag and expected counters.
    logic [31:0] mem_model [logic [29:0]];
    bit          m_valid [8];
    logic [26:0] m_tag   [8];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .arr_idx_o(arr_idx), .arr_we_o(arr_we), .arr_wdata_o(arr_wdata),
        .arr_rdata_i(arr_rdata), .flush_i(flush), .busy_o(busy),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    function automatic logic [31:0] mem_read(input logic [29:0] w);
        if (!mem_model.exists(w)) mem_model[w] = $urandom;
        return mem_model[w];
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    // One CPU access with a memory responder acking on the delay-th request cycle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int delay, input string name);
        logic [2:0]  i;
        logic [26:0] t;
        logic [31:0] exp_data, got;
        bit          exp_hit, done, saw_we, saw_arr_we, addr_ok, arr_ok;
        int          cyc, reqc;
        i = addr[4:2];
        t = addr[31:5];
        exp_hit  = !we && m_valid[i] && (m_tag[i] == t);
        exp_data = we ? wd : mem_read(addr[31:2]);
        done = 0; saw_we = 0; saw_arr_we = 0; addr_ok = 1; arr_ok = 1;
        cyc = 0; reqc = 0; got = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        while (!done && cyc < 64) begin
            mem_ack   = mem_req && (reqc + 1 == delay);
            mem_rdata = mem_ack ? mem_read(addr[31:2]) : $urandom;
            @(negedge clk);
            if (mem_req) begin
                reqc++;
                if (mem_we) saw_we = 1;
                if (mem_addr !== {addr[31:2], 2'b00}) addr_ok = 0;
            end
            if (arr_we) begin
                saw_arr_we = 1;
                if (arr_idx !== i || arr_wdata !== exp_data) arr_ok = 0;
            end
            if (cpu_ready) begin
                done = 1;
                got  = cpu_rdata;
            end
            cyc++;
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; mem_ack = 1'b0;
        chk({name, " ready"}, 32'(done), 32'd1);
        if (!we) chk({name, " rdata"}, got, exp_data);
        chk({name, " mem_req_cycles"}, 32'(reqc), exp_hit ? 32'd0 : 32'(delay));
        chk({name, " latency"}, 32'(cyc), exp_hit ? 32'd1 : 32'(delay + 1));
        chk({name, " mem_we"}, 32'(saw_we), 32'(we));
        chk({name, " arr_we"}, {30'd0, arr_ok, saw_arr_we}, {30'd0, 1'b1, !exp_hit});
        chk({name, " mem_addr"}, 32'(addr_ok), 32'd1);
        if (exp_hit) begin
            if (exp_hits < 65535) exp_hits++;
        end else begin
            if (!we && exp_misses < 65535) exp_misses++;
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            if (we) mem_model[addr[31:2]] = wd;
        end
        chk({name, " hit_cnt"}, 32'(hit_cnt), 32'(exp_hits));
        chk({name, " miss_cnt"}, 32'(miss_cnt), 32'(exp_misses));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 0; mem_rdata = '0; flush = 0;
        model_flush();
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset counters", {hit_cnt, miss_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss, then hit on the same word.
        mem_model[30'h10] = 32'hDEADBEEF;
        access(1'b0, 32'h0000_0040, '0, 3, "miss_40");
        chk("miss_40 miss_cnt", 32'(miss_cnt), 32'd1);
        access(1'b0, 32'h0000_0040, '0, 3, "hit_40");
        chk("hit_40 hit_cnt", 32'(hit_cnt), 32'd1);

        // Conflict on index 0.
        access(1'b0, 32'h0000_0060, '0, 2, "conflict_60");
        access(1'b0, 32'h0000_0040, '0, 1, "conflict_40");
        chk("conflict miss_cnt", 32'(miss_cnt), 32'd3);

        // Store allocates, then load hits with the stored value.
        access(1'b1, 32'h0000_0084, 32'h1234_5678, 2, "store_84");
        access(1'b0, 32'h0000_0084, '0, 2, "load_84");

        // Flush wins over a same-cycle load to a cached line.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040; flush = 1'b1;
        @(negedge clk);
        chk("flush ready", 32'(cpu_ready), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0; flush = 1'b0;
        model_flush();
        chk("flush counters", {hit_cnt, miss_cnt}, {16'(exp_hits), 16'(exp_misses)});
        access(1'b0, 32'h0000_0040, '0, 2, "after_flush");

        // Random traffic over a small tag pool to mix hits, misses and conflicts.
        for (int n = 0; n < 150; n++) begin
            a = {25'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 19) == 0) do_flush();
            access(1'($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(1, 4), "rand");
        end

        // Reset in the middle of a fill.
        do_flush();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0A08;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midfill mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("midfill reset mem_req", 32'(mem_req), 32'd0);
        chk("midfill reset busy", 32'(busy), 32'd0);
        chk("midfill reset counters", {hit_cnt, miss_cnt}, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0; rst = 1'b0;
        model_flush();
        exp_hits = 0; exp_misses = 0;
        @(posedge clk); #1;
        access(1'b0, 32'h0000_0A08, '0, 2, "after_reset");

        // Drive the hit counter to all-ones, then one more hit.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0A08;
        repeat (65535) @(posedge clk);
        #1;
        cpu_req = 1'b0;
        exp_hits = 65535;
        chk("sat hit_cnt", 32'(hit_cnt), 32'h0000_FFFF);
        access(1'b0, 32'h0000_0A08, '0, 2, "sat_extra");
        chk("sat hold", 32'(hit_cnt), 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
